// File: rtl/apb_cmd_master.sv
//------------------------------------------------------------------------------
// apb_cmd_master : valid/ready command stream to single APB transfers, with a
//                  wait-state timeout and a registered response channel.
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apb_cmd_master #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int NUM_SLAVES = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [3:0]            cmd_sel,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_timeout,
    output logic                  rsp_decerr,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
    logic                  r_cmd_ready, w_cmd_ready_nxt;
    logic [NUM_SLAVES-1:0] r_psel,      w_psel_nxt;
    logic                  r_penable,   w_penable_nxt;
    logic [ADDR_W-1:0]     r_paddr,     w_paddr_nxt;
    logic [DATA_W-1:0]     r_pwdata,    w_pwdata_nxt;
    logic                  r_pwrite,    w_pwrite_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
    logic                  r_rsp_to,    w_rsp_to_nxt;
    logic                  r_rsp_dec,   w_rsp_dec_nxt;

    logic [NUM_SLAVES-1:0] w_sel_dec;
    logic                  w_sel_legal;
    logic [CNT_W-1:0]      w_cnt_inc;

    always_comb begin
        w_sel_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_sel_dec[i] = (int'(cmd_sel) == i);
        end
    end

    assign w_sel_legal = (int'(cmd_sel) < NUM_SLAVES);
    assign w_cnt_inc   = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_psel_nxt      = r_psel;
        w_penable_nxt   = r_penable;
        w_paddr_nxt     = r_paddr;
        w_pwdata_nxt    = r_pwdata;
        w_pwrite_nxt    = r_pwrite;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_to_nxt    = r_rsp_to;
        w_rsp_dec_nxt   = r_rsp_dec;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    if (w_sel_legal) begin
                        w_state_nxt  = S_SETUP;
                        w_cnt_nxt    = '0;
                        w_psel_nxt   = w_sel_dec;
                        w_paddr_nxt  = cmd_addr;
                        w_pwdata_nxt = cmd_wdata;
                        w_pwrite_nxt = cmd_write;
                    end else begin
                        // Out-of-range slave: answer directly, bus stays quiet
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = '0;
                        w_rsp_to_nxt    = 1'b0;
                        w_rsp_dec_nxt   = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                w_state_nxt   = S_ACCESS;
                w_penable_nxt = 1'b1;
            end
            S_ACCESS: begin
                // PREADY wins over a timeout landing on the same edge
                if (PREADY) begin
                    w_state_nxt     = S_RESP;
                    w_psel_nxt      = '0;
                    w_penable_nxt   = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : PRDATA;
                    w_rsp_to_nxt    = 1'b0;
                    w_rsp_dec_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
                        w_state_nxt     = S_RESP;
                        w_psel_nxt      = '0;
                        w_penable_nxt   = 1'b0;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = '0;
                        w_rsp_to_nxt    = 1'b1;
                        w_rsp_dec_nxt   = 1'b0;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                    w_rsp_rdata_nxt = '0;
                    w_rsp_to_nxt    = 1'b0;
                    w_rsp_dec_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pwrite    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_to    <= 1'b0;
            r_rsp_dec   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pwdata    <= w_pwdata_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_to    <= w_rsp_to_nxt;
            r_rsp_dec   <= w_rsp_dec_nxt;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PWRITE      = r_pwrite;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_to;
    assign rsp_decerr  = r_rsp_dec;

endmodule

`default_nettype wire

// File: doc/apb_cmd_master.md
# apb_cmd_master

Synthesizable APB master that turns a simple valid/ready command stream into single APB transfers. It drives the shared APB bus that the APB monitor observes and the SPI register slaves answer. It sits between the test harness or embedded sequencer and the APB fabric: one outstanding transfer, a bounded wait-state timeout, and a registered response channel back upstream.

## Interface
Parameters:
- ADDR_W, 16, PADDR and cmd_addr width
- DATA_W, 16, PWDATA/PRDATA width
- NUM_SLAVES, 16, PSEL width; legal cmd_sel range 0..NUM_SLAVES-1
- TIMEOUT, 15, maximum ACCESS wait cycles with PREADY low before abort; legal range 1..255

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block accepts command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- cmd_sel  in  4  slave index, selects PSEL bit
- rsp_valid  out  1  response present
- rsp_ready  in  1  upstream consumes response
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_timeout  out  1  transfer aborted by timeout
- rsp_decerr  out  1  cmd_sel out of range, no bus transfer
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB slave ready

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs registered.
- IDLE: cmd_ready=1. Accept on cmd_valid&&cmd_ready. Latch addr, wdata, write, sel.
- Legal sel: go to SETUP. Out-of-range sel: go to RESP with rsp_decerr=1 and no PSEL bit.
- SETUP, one cycle: PSEL[sel]=1, PENABLE=0, PADDR/PWDATA/PWRITE valid. PREADY ignored. Next state is ACCESS.
- ACCESS: PSEL[sel]=1, PENABLE=1.
  - Edge with PREADY=1: capture PRDATA into rsp_rdata for reads, 0 for writes. Go to RESP.
  - Wait counter counts ACCESS cycles with PREADY=0.
  - Counter reaches TIMEOUT: abort, go to RESP, rsp_timeout=1, rsp_rdata=0.
- RESP: rsp_valid=1, PSEL=0, PENABLE=0. Response fields stable until the rsp_valid&&rsp_ready edge, then IDLE. cmd_ready is 0 throughout.
- PADDR, PWDATA and PWRITE hold their last values outside transfers.
- Wait counter clears on SETUP entry. Width is ceil(log2(TIMEOUT+1)).

## Timing
- Reset values: every output 0, FSM IDLE, counter 0. cmd_ready rises in the first cycle after PRESET deasserts.
- Reset during a transfer: PSEL, PENABLE and rsp_valid are 0 in the cycle after the reset edge. The pending response is discarded.
- Zero-wait transfer:
  - Accept edge E0.
  - SETUP in cycle E0+1.
  - ACCESS in cycle E0+2 with PREADY=1.
  - rsp_valid in cycle E0+3.
  - Earliest next accept is the edge after the rsp handshake.
- N wait states (N<TIMEOUT) add N cycles of ACCESS.
- PREADY rising on the exact cycle the counter hits TIMEOUT counts as completion, not timeout.
- Decode error: rsp_valid in cycle E0+1. No APB activity.
- PSEL never has more than one bit set. PENABLE=1 only in the cycle after SETUP or while in ACCESS.
- cmd_valid asserted while the block is busy is ignored. It is not queued.

## Test plan
- Write sel=3 addr=0x0010 wdata=0xA5A5, PREADY=1 -> SETUP then one ACCESS cycle with PSEL=0x0008, PWRITE=1; rsp_valid at E0+3, rsp_rdata=0, no error flags.
- Read sel=0 addr=0x0004, PREADY low 3 cycles then high with PRDATA=0x1234 -> 4 ACCESS cycles; rsp_rdata=0x1234.
- Read with PREADY held low, TIMEOUT=15 -> 15 ACCESS cycles, then PSEL=0 and rsp_timeout=1, rsp_rdata=0.
- Back-to-back commands with rsp_ready held low for 5 cycles -> rsp fields stable, cmd_ready=0 until the handshake, then the second command proceeds.
- Decode-error case: cmd_sel=15 with NUM_SLAVES=8 -> no PSEL bit set; rsp_decerr=1 at E0+1.
- PRESET pulse during ACCESS -> next cycle all outputs 0 and FSM IDLE; a new command completes normally.
